// File: rtl/xgs_axis_line_monitor.sv
// rtl/xgs_axis_line_monitor.sv - passive AXI4-Stream video line tap with per-line beat count/checksum record FIFO
module xgs_axis_line_monitor #(
  parameter int TDATA_WIDTH = 64,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   sclk,
  input  logic                   srst,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tready,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tuser,
  input  logic                   s_axis_tlast,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [CNT_WIDTH-1:0]   rec_line_idx,
  output logic [CNT_WIDTH-1:0]   rec_beat_cnt,
  output logic [31:0]            rec_checksum,
  output logic                   rec_sof,
  output logic                   rec_err,
  output logic [31:0]            frame_cnt,
  output logic                   overflow,
  input  logic                   clr_status
);
  localparam int LANES = TDATA_WIDTH / 32;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int RW    = 2 * CNT_WIDTH + 34;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LINE = 1'b1;

  logic [0:0]           r_state;
  logic                 r_acc_has;
  logic [CNT_WIDTH-1:0] r_beat_cnt;
  logic [CNT_WIDTH-1:0] r_line_idx;
  logic [31:0]          r_csum;
  logic [31:0]          r_frame_cnt;
  logic                 r_overflow;
  logic [RW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;

  logic                 w_beat;
  logic [31:0]          w_beat_sum;
  logic [0:0]           w_state_nx;
  logic                 w_acc_has_nx;
  logic [CNT_WIDTH-1:0] w_beat_nx;
  logic [CNT_WIDTH-1:0] w_line_nx;
  logic [31:0]          w_csum_nx;
  logic                 w_sof_seen;
  logic [1:0]           w_n_push;
  logic [RW-1:0]        w_rec_a;
  logic [RW-1:0]        w_rec_b;
  logic [RW-1:0]        w_rec_close;
  logic                 w_pop;
  logic [AW+1:0]        w_free;
  logic                 w_acc_a;
  logic                 w_acc_b;
  logic                 w_drop;
  logic [1:0]           w_n_acc;
  logic [RW-1:0]        w_head;

  assign w_beat = s_axis_tvalid && s_axis_tready;

  always_comb begin
    w_beat_sum = 32'd0;
    for (int i = 0; i < LANES; i++) w_beat_sum = w_beat_sum + s_axis_tdata[i*32 +: 32];
  end

  // A truncating SOF that also carries tlast yields two records in one cycle: slot a then b.
  always_comb begin
    w_state_nx   = r_state;
    w_acc_has_nx = r_acc_has;
    w_beat_nx    = r_beat_cnt;
    w_line_nx    = r_line_idx;
    w_csum_nx    = r_csum;
    w_sof_seen   = 1'b0;
    w_n_push     = 2'd0;
    w_rec_a      = '0;
    w_rec_b      = '0;
    w_rec_close  = '0;
    if (w_beat && s_axis_tuser) begin
      w_sof_seen = 1'b1;
      if (r_state == S_LINE && r_acc_has) begin
        w_rec_a  = {r_line_idx, r_beat_cnt, r_csum, (r_line_idx == '0), 1'b1};
        w_n_push = 2'd1;
      end
      w_state_nx   = S_LINE;
      w_line_nx    = '0;
      w_beat_nx    = CNT_WIDTH'(1);
      w_csum_nx    = w_beat_sum;
      w_acc_has_nx = 1'b1;
    end else if (w_beat && r_state == S_LINE) begin
      w_beat_nx    = r_beat_cnt + CNT_WIDTH'(1);
      w_csum_nx    = r_csum + w_beat_sum;
      w_acc_has_nx = 1'b1;
    end
    if (w_beat && (s_axis_tuser || r_state == S_LINE) && s_axis_tlast) begin
      w_rec_close = {w_line_nx, w_beat_nx, w_csum_nx, (w_line_nx == '0), 1'b0};
      if (w_n_push == 2'd0) w_rec_a = w_rec_close;
      else                  w_rec_b = w_rec_close;
      w_n_push     = w_n_push + 2'd1;
      w_line_nx    = w_line_nx + CNT_WIDTH'(1);
      w_beat_nx    = '0;
      w_csum_nx    = 32'd0;
      w_acc_has_nx = 1'b0;
    end
  end

  // A pop in the same cycle frees a slot for the incoming record, even when full.
  assign w_pop   = (r_count != '0) && rec_ready;
  assign w_free  = (AW+2)'(FIFO_DEPTH) - (AW+2)'(r_count) + (AW+2)'(w_pop);
  assign w_acc_a = (w_n_push != 2'd0) && (w_free != '0);
  assign w_acc_b = (w_n_push == 2'd2) && (w_free >= (AW+2)'(2));
  assign w_drop  = ((w_n_push != 2'd0) && !w_acc_a) || ((w_n_push == 2'd2) && !w_acc_b);
  assign w_n_acc = {1'b0, w_acc_a} + {1'b0, w_acc_b};

  always_ff @(posedge sclk) begin
    if (srst) begin
      r_state     <= S_IDLE;
      r_acc_has   <= 1'b0;
      r_beat_cnt  <= '0;
      r_line_idx  <= '0;
      r_csum      <= 32'd0;
      r_frame_cnt <= 32'd0;
      r_overflow  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_acc_has   <= w_acc_has_nx;
      r_beat_cnt  <= w_beat_nx;
      r_line_idx  <= w_line_nx;
      r_csum      <= w_csum_nx;
      r_frame_cnt <= (clr_status ? 32'd0 : r_frame_cnt) + 32'(w_sof_seen);
      r_overflow  <= (r_overflow && !clr_status) || w_drop;
      r_wr_ptr    <= r_wr_ptr + AW'(w_n_acc);
      r_rd_ptr    <= r_rd_ptr + AW'(w_pop);
      r_count     <= r_count + (AW+1)'(w_n_acc) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge sclk) begin
    if (w_acc_a) r_mem[r_wr_ptr] <= w_rec_a;
    if (w_acc_b) r_mem[r_wr_ptr + AW'(1)] <= w_rec_b;
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign rec_valid = (r_count != '0);
  assign {rec_line_idx, rec_beat_cnt, rec_checksum, rec_sof, rec_err} = rec_valid ? w_head : '0;
  assign frame_cnt = r_frame_cnt;
  assign overflow  = r_overflow;
endmodule

// File: doc/xgs_axis_line_monitor.md
Name: xgs_axis_line_monitor

Overview:
- Passive tap on the Athena AXI4-Stream video output (tuser = start-of-frame, tlast = end-of-line), sitting directly upstream of the image scoreboard.
- Per line, it counts beats and computes a 32-bit checksum, then queues one record in a small first-word-fall-through (FWFT) FIFO.
- The scoreboard drains these records and compares them against its expected image.
- It never back-pressures the video path.

Parameters:
- TDATA_WIDTH, 64, stream data width; a multiple of 32, max 256.
- FIFO_DEPTH, 16, record FIFO depth; a power of 2, minimum 2.
- CNT_WIDTH, 16, width of the line-index and beat counters.

Ports:
- sclk  in  1  system clock
- srst  in  1  synchronous reset, active-high
- s_axis_tvalid  in  1  tapped valid
- s_axis_tready  in  1  tapped ready (observed only)
- s_axis_tdata  in  TDATA_WIDTH  tapped data
- s_axis_tuser  in  1  SOF, meaningful on the first beat of a frame
- s_axis_tlast  in  1  end of line
- rec_valid  out  1  FIFO head record valid
- rec_ready  in  1  consumer pops the head when rec_valid && rec_ready
- rec_line_idx  out  CNT_WIDTH  line index within the frame, 0-based
- rec_beat_cnt  out  CNT_WIDTH  beats in the line
- rec_checksum  out  32  line checksum
- rec_sof  out  1  record is line 0 of a frame
- rec_err  out  1  line truncated by an unexpected SOF
- frame_cnt  out  32  count of SOFs seen
- overflow  out  1  sticky: a record was dropped because the FIFO was full
- clr_status  in  1  clears overflow and frame_cnt

Behaviour:
- Beat qualifier: a beat is s_axis_tvalid && s_axis_tready. All other cycles are ignored.
- Checksum: the modulo-2^32 sum of every 32-bit lane of every beat in the line.
- Beat count: wraps modulo 2^CNT_WIDTH.
- Line index: wraps modulo 2^CNT_WIDTH.
- FSM states: IDLE and LINE.
- IDLE:
  - Beats without SOF are discarded.
  - A beat with SOF: line_idx = 0, beat count = 1, checksum = sum of that beat, frame_cnt++.
  - If that beat also has tlast, the record is written immediately and the FSM stays in IDLE-equivalent "between lines" tracking. Otherwise it goes to LINE.
- Between lines within a frame: frame_started = 1 and the FSM waits in LINE with an empty accumulator.
- LINE, beat without SOF: accumulate. On tlast, write the record {line_idx, beat_cnt incl. this beat, checksum incl. this beat, sof = (line_idx == 0), err = 0}, then clear the accumulator and increment line_idx.
- LINE, SOF beat while the accumulator is non-empty:
  - Write a record for the partial line with err = 1, sof per its index.
  - Restart as in IDLE from this beat; frame_cnt++.
  - Both happen in the same cycle.
- LINE, SOF beat with an empty accumulator: normal new-frame start, line_idx = 0, frame_cnt++, no error.
- Record write timing:
  - The record is registered at the clock edge ending the triggering beat.
  - rec_valid rises the next cycle (1-cycle latency) if the FIFO was empty.
- FIFO:
  - FWFT; rec_* outputs reflect the head entry.
  - Simultaneous push and pop is legal at any occupancy, including full: the pop frees a slot and the push is accepted.
  - Push when full with no pop: the record is dropped and overflow is set.
- clr_status:
  - Clears overflow and frame_cnt on the next edge.
  - If an SOF beat coincides, frame_cnt = 1 after that edge.
- Reset:
  - srst has priority over everything.
  - After reset: FSM = IDLE, FIFO empty, rec_valid = 0.
  - All rec_* data outputs = 0, frame_cnt = 0, overflow = 0.
  - A line in progress at reset is discarded with no record.

Test Plan:
- Frame, 2 lines × 3 beats, TDATA 64:
  - Stimulus: each beat's 32-bit lanes = 1 and 2.
  - Response: two records {0,3,9,sof=1,err=0} and {1,3,9,0,0}; frame_cnt = 1; rec_valid rises 1 cycle after each tlast beat.
- Backpressure on the tap:
  - Stimulus: tvalid = 1 with tready toggling 1/0.
  - Response: beat_cnt counts only handshakes (3 handshakes over 6 cycles → beat_cnt = 3).
- Truncated line:
  - Stimulus: SOF, 2 beats without tlast, then a new SOF line of 1 beat with tlast.
  - Response: records {0,2,sum,1,err=1} then {0,1,sum,1,0}; frame_cnt = 2.
- Overflow:
  - Stimulus: rec_ready = 0, send 17 lines with FIFO_DEPTH = 16.
  - Response: 16 records held, overflow = 1 after the 17th tlast; clr_status clears it.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, rec_ready = 1 in the same cycle as a tlast beat.
  - Response: no drop, overflow stays 0, occupancy stays 16.
- Reset mid-line:
  - Stimulus: srst asserted after 2 beats of a line.
  - Response: no record, rec_valid = 0; a following non-SOF line is ignored until the next SOF.
